regfile_2r1w: RTL and testbench

Parametrised register file, successor to the 8x16 single-port block: one write port and two independent read ports, all usable in the same cycle. Reads are registered with a valid strobe, and same-cycle write/read to one address is bypassed (write-first). Reset clears the storage array as well as the outputs. Sits beside the datapath as an operand store: one result write and two operand reads per cycle.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_rd_port.sv | 79 +++++++
 rtl/regfile_2r1w.sv | 137 +++++++++++++
 tb/tb_regfile_2r1w.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the 2-read / 1-write register file.
//   REGFILE_DATA_W / REGFILE_ADDR_W / REGFILE_DEPTH : default geometry
//   clog2(value) : minimum address width (at least 1) needed to index
//                  'value' entries, for callers deriving ADDR_W from DEPTH
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REGFILE_DATA_W = 16;
  localparam int REGFILE_ADDR_W = 3;
  localparam int REGFILE_DEPTH  = 8;

  // Ceiling log2, clamped to 1 so a single-entry file still has an address bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        width = i + 1;
      end else begin
        width = width;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// ---------------------------------------------------------------------------
// regfile_rd_port
// One registered read port of the register file.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_rd_en, i_rd_addr  : read request and address
//   i_entry_data        : storage word selected by i_rd_addr (from the top)
//   i_wr_en, i_wr_addr,
//   i_wr_data           : same-cycle write, used for write-first bypass
//   o_rd_data           : registered read data (holds when no request)
//   o_rd_valid          : one-cycle strobe, o_rd_data updated this cycle
//   o_addr_oor          : combinational, enabled read to address >= DEPTH
// ---------------------------------------------------------------------------
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int                 DATA_W  = REGFILE_DATA_W,
  parameter int                 ADDR_W  = REGFILE_ADDR_W,
  parameter int                 DEPTH   = REGFILE_DEPTH,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_entry_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_addr_oor
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              w_in_range;
  logic              w_bypass;
  logic [DATA_W-1:0] w_rd_next;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  assign w_in_range = ({1'b0, i_rd_addr} < DEPTH_L);

  // An in-range read address that equals the write address implies the
  // write is in range too, so the write-side range check is not repeated.
  assign w_bypass   = i_wr_en & (i_wr_addr == i_rd_addr) & w_in_range;

  assign o_addr_oor = i_rd_en & ~w_in_range;

  // Select the word to capture: out-of-range, then bypass, then storage.
  always_comb begin
    w_rd_next = RST_VAL;
    if (!w_in_range) begin
      w_rd_next = RST_VAL;
    end else if (w_bypass) begin
      w_rd_next = i_wr_data;
    end else begin
      w_rd_next = i_entry_data;
    end
  end

  // Output data/valid registers; data holds when no read is requested.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data  <= RST_VAL;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= w_rd_next;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
// Parametrised register file: one write port and two independent registered
// read ports, all usable every cycle, with write-first bypass.
//   CLK, RST          : clock, synchronous active-high reset (clears storage)
//   WrEn/WrAddr/WrData: write port, out-of-range writes are dropped
//   RdEnA/RdAddrA     : read request port A -> RdDataA/RdValidA next cycle
//   RdEnB/RdAddrB     : read request port B -> RdDataB/RdValidB next cycle
//   AddrErr           : registered, 1 for one cycle after any enabled access
//                       (write or either read) to an address >= DEPTH
// ---------------------------------------------------------------------------
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int                 DATA_W  = REGFILE_DATA_W,
  parameter int                 ADDR_W  = REGFILE_ADDR_W,
  parameter int                 DEPTH   = REGFILE_DEPTH,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdEnA,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [DATA_W-1:0] RdDataA,
  output logic              RdValidA,
  input  logic              RdEnB,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] RdDataB,
  output logic              RdValidB,
  output logic              AddrErr
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_wr_sel;
  logic              w_wr_oor;
  logic [DATA_W-1:0] w_entry_a;
  logic [DATA_W-1:0] w_entry_b;
  logic              w_oor_a;
  logic              w_oor_b;
  logic              r_addr_err;

  assign w_wr_oor = WrEn & ~({1'b0, WrAddr} < DEPTH_L);

  // One-hot write decode; an out-of-range address matches no entry.
  always_comb begin
    w_wr_sel = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (WrEn && (WrAddr == ADDR_W'(i))) begin
        w_wr_sel[i] = 1'b1;
      end else begin
        w_wr_sel[i] = 1'b0;
      end
    end
  end

  // Storage array: cleared on reset, otherwise updated by the decoded write.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (RST) begin
        r_mem[i] <= RST_VAL;
      end else if (w_wr_sel[i]) begin
        r_mem[i] <= WrData;
      end
    end
  end

  // Storage fetch per port; guarded so a non-existent entry is never indexed.
  always_comb begin
    w_entry_a = RST_VAL;
    w_entry_b = RST_VAL;
    if ({1'b0, RdAddrA} < DEPTH_L) begin
      w_entry_a = r_mem[RdAddrA];
    end else begin
      w_entry_a = RST_VAL;
    end
    if ({1'b0, RdAddrB} < DEPTH_L) begin
      w_entry_b = r_mem[RdAddrB];
    end else begin
      w_entry_b = RST_VAL;
    end
  end

  regfile_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) u_rd_port_a (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_rd_en      (RdEnA),
    .i_rd_addr    (RdAddrA),
    .i_entry_data (w_entry_a),
    .i_wr_en      (WrEn),
    .i_wr_addr    (WrAddr),
    .i_wr_data    (WrData),
    .o_rd_data    (RdDataA),
    .o_rd_valid   (RdValidA),
    .o_addr_oor   (w_oor_a)
  );

  regfile_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) u_rd_port_b (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_rd_en      (RdEnB),
    .i_rd_addr    (RdAddrB),
    .i_entry_data (w_entry_b),
    .i_wr_en      (WrEn),
    .i_wr_addr    (WrAddr),
    .i_wr_data    (WrData),
    .o_rd_data    (RdDataB),
    .o_rd_valid   (RdValidB),
    .o_addr_oor   (w_oor_b)
  );

  // Address error flag: set for one cycle after any out-of-range access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_wr_oor | w_oor_a | w_oor_b;
    end
  end

  assign AddrErr = r_addr_err;

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  logic        CLK = 1'b0;
  logic        RST, WrEn, RdEnA, RdEnB;
  logic [2:0]  WrAddr, RdAddrA, RdAddrB;
  logic [15:0] WrData;

  logic [15:0] da8, db8, da6, db6;
  logic        va8, vb8, err8, va6, vb6, err6;

  always #5 CLK = ~CLK;

  // Instance 0: full 8-entry file, RST_VAL 0
  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .RST_VAL(16'h0000)) u_dut8 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(da8), .RdValidA(va8),
    .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(db8), .RdValidB(vb8),
    .AddrErr(err8));

  // Instance 1: 6 entries behind a 3-bit address, non-zero RST_VAL
  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .DEPTH(6), .RST_VAL(16'hC3C3)) u_dut6 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(da6), .RdValidA(va6),
    .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(db6), .RdValidB(vb6),
    .AddrErr(err6));

  typedef struct packed {
    logic        va;
    logic [15:0] da;
    logic        vb;
    logic [15:0] db;
    logic        err;
  } exp_t;

  exp_t        q8[$];
  exp_t        q6[$];
  logic [15:0] mem [2][8];
  logic [15:0] last_a [2];
  logic [15:0] last_b [2];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic [15:0] rval(input int k);
    return (k == 0) ? 16'h0000 : 16'hC3C3;
  endfunction

  // What an enabled read of 'addr' returns this cycle (write-first).
  function automatic logic [15:0] read_val(input int k, input int addr);
    if (addr >= depth_of(k)) return rval(k);
    if (WrEn && int'(WrAddr) == addr) return WrData;
    return mem[k][addr];
  endfunction

  // Reference model step at a rising edge; pushes the expected outputs.
  task automatic model_step(input int k);
    exp_t e;
    int   d;
    d = depth_of(k);
    if (RST) begin
      for (int i = 0; i < 8; i++) mem[k][i] = rval(k);
      e.va = 1'b0; e.da = rval(k); e.vb = 1'b0; e.db = rval(k); e.err = 1'b0;
    end else begin
      e.va  = RdEnA;
      e.da  = RdEnA ? read_val(k, int'(RdAddrA)) : last_a[k];
      e.vb  = RdEnB;
      e.db  = RdEnB ? read_val(k, int'(RdAddrB)) : last_b[k];
      e.err = (WrEn && int'(WrAddr) >= d) || (RdEnA && int'(RdAddrA) >= d) ||
              (RdEnB && int'(RdAddrB) >= d);
      if (WrEn && int'(WrAddr) < d) mem[k][int'(WrAddr)] = WrData;
    end
    last_a[k] = e.da;
    last_b[k] = e.db;
    if (k == 0) q8.push_back(e);
    else        q6.push_back(e);
  endtask

  task automatic check(input int k, input exp_t e);
    exp_t a;
    if (k == 0) begin
      a.va = va8; a.da = da8; a.vb = vb8; a.db = db8; a.err = err8;
    end else begin
      a.va = va6; a.da = da6; a.vb = vb6; a.db = db6; a.err = err6;
    end
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL outputs dut%0d t=%0t: got vA=%b dA=%h vB=%b dB=%h err=%b, expected vA=%b dA=%h vB=%b dB=%h err=%b",
               depth_of(k), $time, a.va, a.da, a.vb, a.db, a.err,
               e.va, e.da, e.vb, e.db, e.err);
    end
  endtask

  // Monitor: compare whatever the DUTs present against the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (q8.size() > 0) check(0, q8.pop_front());
      if (q6.size() > 0) check(1, q6.pop_front());
    end
  end

  task automatic step(input int rst, input int we, input int wa, input int wd,
                      input int rea, input int aa, input int reb, input int ab);
    RST     = rst[0];
    WrEn    = we[0];
    WrAddr  = 3'(wa);
    WrData  = 16'(wd);
    RdEnA   = rea[0];
    RdAddrA = 3'(aa);
    RdEnB   = reb[0];
    RdAddrB = 3'(ab);
    @(posedge CLK);
    model_step(0);
    model_step(1);
    cyc++;
    @(negedge CLK);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      last_a[k] = 16'h0000;
      last_b[k] = 16'h0000;
      for (int i = 0; i < 8; i++) mem[k][i] = 16'h0000;
    end
    RST = 1'b1; WrEn = 1'b0; WrAddr = 3'd0; WrData = 16'h0000;
    RdEnA = 1'b0; RdAddrA = 3'd0; RdEnB = 1'b0; RdAddrB = 3'd0;
    @(negedge CLK);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset clear: fill, pulse reset, read everything back on both ports
    for (int i = 0; i < 8; i++) step(0, 1, i, 'h1234, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, i, 1, 7 - i);

    // Basic write/read latency, then hold with RdEnA=0
    step(0, 1, 3, 'hA5A5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Bypass on both ports, then a plain read of the same entry
    step(0, 1, 5, 'h1111, 0, 0, 0, 0);
    step(0, 1, 5, 'h2222, 1, 5, 1, 5);
    step(0, 0, 0, 0, 1, 5, 1, 5);

    // Concurrent independent write + two reads, no bubbles
    for (int i = 2; i < 8; i++) step(0, 1, i, 'h0100 + i, 1, i - 1, 1, i - 2);

    // Out of range (relevant to the 6-entry instance)
    step(0, 1, 6, 'hFFFF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 6, 1, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, i, 1, 5 - i);

    // Reset mid-stream with a write and a read to entry 2
    step(0, 1, 2, 'h7777, 0, 0, 0, 0);
    step(1, 1, 2, 'hBEEF, 1, 2, 0, 0);
    step(0, 0, 0, 0, 1, 2, 1, 2);

    // Randomised traffic, occasional reset
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0) ? 1 : 0,
           int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 5 && (q8.size() > 0 || q6.size() > 0); w++) @(negedge CLK);
    if (q8.size() > 0 || q6.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d/%0d expected entries left, expected 0/0", q8.size(), q6.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
